weight_ram_loader: RTL

WEIGHT_RAM_LOADER -- requirements
Module: weight_ram_loader

---
 rtl/weight_ram_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/weight_ram_loader.sv
// Streaming loader that writes a burst of words into a local RAM starting at a
// given base address, with a synchronous read port for the consumer.
module weight_ram_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          word_count,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned SUM_W     = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [CNT_W-1:0]        remaining;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [SUM_W-1:0]        end_addr_c;
  logic                    start_ok_c;
  logic                    start_bad_c;
  logic                    wr_en_c;
  logic                    last_c;

  // One bit of headroom so base+count can reach MEM_DEPTH without wrapping.
  assign end_addr_c = SUM_W'(base_addr) + SUM_W'(word_count);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt   = state;
    start_ok_c  = 1'b0;
    start_bad_c = 1'b0;
    wr_en_c     = 1'b0;
    last_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((word_count == '0) || (end_addr_c > SUM_W'(MEM_DEPTH))) begin
            start_bad_c = 1'b1;
          end else begin
            start_ok_c = 1'b1;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          wr_en_c = 1'b1;
          if (remaining == CNT_W'(1)) begin
            last_c    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, status flags, burst pointers and read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      remaining <= '0;
      rd_data   <= '0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == LOAD);
      busy    <= (state_nxt == LOAD);
      done    <= (state_nxt == DONE);
      rd_data <= $signed(mem[rd_addr]);
      if (start_bad_c) begin
        err <= 1'b1;
      end else if (start_ok_c) begin
        err <= 1'b0;
      end
      if (start_ok_c) begin
        wr_ptr    <= base_addr;
        remaining <= word_count;
      end else if (wr_en_c) begin
        remaining <= remaining - CNT_W'(1);
        // Hold the pointer on the last word so a burst ending at the top never wraps.
        if (!last_c) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Storage is deliberately not reset so loaded weights survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule
